// File: rtl/icache_direct.sv
// icache_direct: direct-mapped, read-only instruction cache between the
// datapath fetch port and the memory controller instruction port.
// Hits answer combinationally; a miss issues one word read and fills the frame.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module icache_direct #(
  parameter int NUM_SETS = 16,
  parameter int WORD_W   = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              imemREN,
  input  logic [WORD_W-1:0] imemaddr,
  input  logic              halt,
  output logic              ihit,
  output logic [WORD_W-1:0] imemload,
  output logic              iREN,
  output logic [WORD_W-1:0] iaddr,
  input  logic              iwait,
  input  logic [WORD_W-1:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = WORD_W - IDX_W - 2;

  typedef enum logic {IDLE, MISS} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] miss_addr_q, miss_addr_d;

  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [WORD_W-1:0]   data_q [NUM_SETS];

  logic [IDX_W-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0] req_tag, fill_tag;
  logic             req_ok, hit, miss_start, fill;

  // Byte-offset bits select nothing: every fetch is a whole word.
  logic unused_byte_bits;
  assign unused_byte_bits = ^imemaddr[1:0];

  assign req_idx  = imemaddr[IDX_W+1:2];
  assign req_tag  = imemaddr[WORD_W-1:IDX_W+2];
  assign fill_idx = miss_addr_q[IDX_W+1:2];
  assign fill_tag = miss_addr_q[WORD_W-1:IDX_W+2];

  // A halted datapath may still read cached words... but a halt blocks the
  // hit too, so a halted request simply sees ihit=0 and starts nothing.
  assign req_ok     = (state_q == IDLE) && !RST && imemREN && !halt;
  assign hit        = req_ok && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign miss_start = req_ok && !hit;
  // A fill lands on the edge where memory drops iwait, unless reset wins.
  assign fill       = (state_q == MISS) && !iwait && !RST;

  // State register: control state and the latched miss address.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  // Next-state logic: a started fill always runs to completion.
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    case (state_q)
      IDLE: begin
        if (miss_start) begin
          state_d     = MISS;
          miss_addr_d = {imemaddr[WORD_W-1:2], 2'b00};
        end
      end
      MISS: begin
        if (!iwait) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: everything is forced quiet while reset is held.
  always_comb begin
    ihit     = 1'b0;
    imemload = '0;
    iREN     = 1'b0;
    iaddr    = '0;
    if (!RST) begin
      case (state_q)
        IDLE: begin
          ihit     = hit;
          imemload = hit ? data_q[req_idx] : '0;
        end
        MISS: begin
          iREN  = 1'b1;
          iaddr = miss_addr_q;
        end
        default: ;
      endcase
    end
  end

  // Valid bits: cleared by reset, set by a completed fill.
  always_ff @(posedge CLK) begin
    if (RST) valid_q <= '0;
    else if (fill) valid_q[fill_idx] <= 1'b1;
  end

  // Tag and data storage: overwritten unconditionally on fill (no reset needed).
  always_ff @(posedge CLK) begin
    if (fill) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q, miss_count_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Saturating hit and miss counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (hit)        hit_count_q  <= sat_inc(hit_count_q);
      if (miss_start) miss_count_q <= sat_inc(miss_count_q);
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule
